// File: rtl/button_debounce.sv
// button_debounce: synchronizes and debounces a raw pushbutton into a level, press/release/long strobes and a press counter
//   sysClk       : the only clock
//   rst          : synchronous active-high reset
//   btnIn        : raw button pin, asynchronous to sysClk
//   pressed      : debounced level, 1 while the button is accepted as held
//   pressPulse   : one-cycle strobe on an accepted press
//   releasePulse : one-cycle strobe on an accepted release
//   longPulse    : one-cycle strobe once a press has been held LONG_CYCLES cycles
//   pressCount   : accepted presses modulo 256
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int LONG_CYCLES     = 100_000_000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic       sysClk,
  input  logic       rst,
  input  logic       btnIn,
  output logic       pressed,
  output logic       pressPulse,
  output logic       releasePulse,
  output logic       longPulse,
  output logic [7:0] pressCount
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int LW = $clog2(LONG_CYCLES);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [LW-1:0] LONG_LAST = LW'(LONG_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;
  state_t state_q, state_d;
  logic s1_q, s2_q;
  logic [DW-1:0] db_q, db_d;
  logic [LW-1:0] hold_q, hold_d;
  logic long_done_q, long_done_d;
  logic pressed_q, pressed_d;
  logic press_q, press_d;
  logic release_q, release_d;
  logic long_q, long_d;
  logic [7:0] cnt_q, cnt_d;
  always_ff @(posedge sysClk) begin
    if (rst) begin
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      state_q     <= IDLE;
      db_q        <= '0;
      hold_q      <= '0;
      long_done_q <= 1'b0;
      pressed_q   <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      long_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      // normalise polarity so the synchronized signal is 1 while pressed
      s1_q        <= btnIn ^ ACTIVE_LOW;
      s2_q        <= s1_q;
      state_q     <= state_d;
      db_q        <= db_d;
      hold_q      <= hold_d;
      long_done_q <= long_done_d;
      pressed_q   <= pressed_d;
      press_q     <= press_d;
      release_q   <= release_d;
      long_q      <= long_d;
      cnt_q       <= cnt_d;
    end
  end
  always_comb begin
    state_d     = state_q;
    db_d        = db_q;
    hold_d      = hold_q;
    long_done_d = long_done_q;
    pressed_d   = pressed_q;
    press_d     = 1'b0;
    release_d   = 1'b0;
    long_d      = 1'b0;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: begin
        if (s2_q) begin
          state_d = PRESS_WAIT;
          db_d    = '0;
        end
      end
      PRESS_WAIT: begin
        if (!s2_q) state_d = IDLE;
        else if (db_q == DB_LAST) begin
          state_d     = HELD;
          pressed_d   = 1'b1;
          press_d     = 1'b1;
          cnt_d       = cnt_q + 8'd1;
          hold_d      = '0;
          long_done_d = 1'b0;
        end else db_d = db_q + DW'(1);
      end
      HELD: begin
        // a release bounce parks holdCnt until we come back here
        if (!s2_q) begin
          state_d = RELEASE_WAIT;
          db_d    = '0;
        end else if (hold_q == LONG_LAST && !long_done_q) begin
          long_d      = 1'b1;
          long_done_d = 1'b1;
        end else if (hold_q < LONG_LAST) hold_d = hold_q + LW'(1);
      end
      RELEASE_WAIT: begin
        if (s2_q) state_d = HELD;
        else if (db_q == DB_LAST) begin
          state_d   = IDLE;
          pressed_d = 1'b0;
          release_d = 1'b1;
        end else db_d = db_q + DW'(1);
      end
      default: state_d = IDLE;
    endcase
  end
  assign pressed      = pressed_q;
  assign pressPulse   = press_q;
  assign releasePulse = release_q;
  assign longPulse    = long_q;
  assign pressCount   = cnt_q;
endmodule

// File: tb/tb_button_debounce.sv
// tb_button_debounce: scoreboard bench for button_debounce, one active-low and one active-high instance
module tb_button_debounce;
  localparam logic [2:0] K_PRESS = 3'b100;
  localparam logic [2:0] K_REL   = 3'b010;
  localparam logic [2:0] K_LONG  = 3'b001;
  typedef struct {
    int         cyc;
    logic [2:0] k;
    logic [7:0] c;
    logic       pr;
  } ev_t;
  logic clk = 1'b0;
  logic [1:0] rst = 2'b11;
  logic [1:0] btn = 2'b01;
  logic [1:0] pr, pp, rp, lp;
  logic [7:0] cnt [2];
  logic [7:0] exp_cnt [2];
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  ev_t q0[$];
  ev_t q1[$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  button_debounce #(.DEBOUNCE_CYCLES(4), .LONG_CYCLES(20), .ACTIVE_LOW(1'b1)) dut0 (
    .sysClk(clk), .rst(rst[0]), .btnIn(btn[0]), .pressed(pr[0]), .pressPulse(pp[0]),
    .releasePulse(rp[0]), .longPulse(lp[0]), .pressCount(cnt[0])
  );
  button_debounce #(.DEBOUNCE_CYCLES(4), .LONG_CYCLES(20), .ACTIVE_LOW(1'b0)) dut1 (
    .sysClk(clk), .rst(rst[1]), .btnIn(btn[1]), .pressed(pr[1]), .pressPulse(pp[1]),
    .releasePulse(rp[1]), .longPulse(lp[1]), .pressCount(cnt[1])
  );
  task automatic mon(input int d);
    ev_t e;
    if (!(pp[d] | rp[d] | lp[d])) return;
    checks++;
    if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
      errors++;
      $display("FAIL unexpected_pulse dut%0d cyc %0d got pp%b rp%b lp%b cnt %0d", d, cyc, pp[d], rp[d], lp[d], cnt[d]);
      return;
    end
    if (d == 0) e = q0.pop_front();
    else e = q1.pop_front();
    if (e.cyc != cyc || e.k != {pp[d], rp[d], lp[d]} || e.c != cnt[d] || e.pr != pr[d]) begin
      errors++;
      $display("FAIL pulse dut%0d got cyc %0d kind %b cnt %0d pressed %b, need cyc %0d kind %b cnt %0d pressed %b",
               d, cyc, {pp[d], rp[d], lp[d]}, cnt[d], pr[d], e.cyc, e.k, e.c, e.pr);
    end
  endtask
  always @(negedge clk) begin
    mon(0);
    mon(1);
  end
  task automatic chk(input string name, input int got, input int need);
    checks++;
    if (got != need) begin
      errors++;
      $display("FAIL %s got %0d need %0d", name, got, need);
    end
  endtask
  task automatic step(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask
  task automatic drive(input int d, input bit act);
    btn[d] = (d == 0) ? ~act : act;
  endtask
  task automatic push(input int d, input int at, input logic [2:0] k, input logic p);
    ev_t e;
    if (k == K_PRESS) exp_cnt[d] = exp_cnt[d] + 8'd1;
    e.cyc = at;
    e.k = k;
    e.c = exp_cnt[d];
    e.pr = p;
    if (d == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask
  task automatic check_zero(input int d);
    chk($sformatf("rst_pressed%0d", d), int'(pr[d]), 0);
    chk($sformatf("rst_press%0d", d), int'(pp[d]), 0);
    chk($sformatf("rst_release%0d", d), int'(rp[d]), 0);
    chk($sformatf("rst_long%0d", d), int'(lp[d]), 0);
    chk($sformatf("rst_count%0d", d), int'(cnt[d]), 0);
  endtask
  task automatic do_reset(input int d);
    rst[d] = 1'b1;
    step(1);
    rst[d] = 1'b0;
    exp_cnt[d] = 8'd0;
    check_zero(d);
  endtask
  // press at the next edge, pulse appears 2 sync + 4 debounce edges later
  task automatic clean_press(input int d, input int hold);
    drive(d, 1'b1);
    push(d, cyc + 7, K_PRESS, 1'b1);
    step(hold);
    drive(d, 1'b0);
    push(d, cyc + 7, K_REL, 1'b0);
    step(12);
  endtask
  initial begin
    int p;
    exp_cnt[0] = 8'd0;
    exp_cnt[1] = 8'd0;
    step(3);
    rst = 2'b00;
    check_zero(0);
    check_zero(1);
    step(2);
    clean_press(0, 10);
    chk("count_after_clean", int'(cnt[0]), 1);
    repeat (5) begin
      drive(0, 1'b1);
      step(3);
      drive(0, 1'b0);
      step(1);
    end
    clean_press(0, 10);
    chk("count_after_bounce", int'(cnt[0]), 2);
    drive(0, 1'b1);
    p = cyc + 7;
    push(0, p, K_PRESS, 1'b1);
    push(0, p + 20, K_LONG, 1'b1);
    step(40);
    drive(0, 1'b0);
    push(0, cyc + 7, K_REL, 1'b0);
    step(12);
    // a 2-cycle glitch keeps holdCnt still for 3 edges (enter, wait, return)
    drive(0, 1'b1);
    p = cyc + 7;
    push(0, p, K_PRESS, 1'b1);
    step(17);
    drive(0, 1'b0);
    step(2);
    drive(0, 1'b1);
    push(0, p + 23, K_LONG, 1'b1);
    step(p + 40 - cyc);
    drive(0, 1'b0);
    push(0, cyc + 7, K_REL, 1'b0);
    step(12);
    drive(0, 1'b1);
    push(0, cyc + 7, K_PRESS, 1'b1);
    step(10);
    do_reset(0);
    push(0, cyc + 7, K_PRESS, 1'b1);
    step(10);
    chk("count_after_rst_press", int'(cnt[0]), 1);
    drive(0, 1'b0);
    push(0, cyc + 7, K_REL, 1'b0);
    step(12);
    do_reset(0);
    for (int i = 1; i <= 257; i++) begin
      clean_press(0, 8);
      if (i == 255) chk("count_255", int'(cnt[0]), 255);
      if (i == 256) chk("count_256", int'(cnt[0]), 0);
      if (i == 257) chk("count_257", int'(cnt[0]), 1);
    end
    clean_press(1, 10);
    chk("count_polarity", int'(cnt[1]), 1);
    step(5);
    while (q0.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL missing_pulse dut0 got none need cyc %0d kind %b", q0[0].cyc, q0[0].k);
      void'(q0.pop_front());
    end
    while (q1.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL missing_pulse dut1 got none need cyc %0d kind %b", q1[0].cyc, q1[0].k);
      void'(q1.pop_front());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/button_debounce.md
# button_debounce

Conditions one raw, asynchronous pushbutton input into clean, single-clock-domain control signals: a debounced level, one-cycle press and release strobes, a one-cycle long-press strobe, and a wrapping press counter. It is the input-side counterpart of the LED-driving logic. It sits directly behind a board button pin, clocked by the PLL-derived `sysClk`.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 1_000_000 (10 ms at 100 MHz): stable cycles required to accept a level change. Must be ≥ 2.
- `LONG_CYCLES`, default 100_000_000 (1 s): held cycles before the long-press strobe. Must be ≥ 2.
- `ACTIVE_LOW`, default 1: 1 means the pin reads 0 when pressed.

Ports:
- `sysClk` in 1: the only clock.
- `rst` in 1: synchronous, active-high reset.
- `btnIn` in 1: raw pin, asynchronous to `sysClk`.
- `pressed` out 1: debounced level, 1 while the button is accepted as held.
- `pressPulse` out 1: high for one cycle on an accepted press.
- `releasePulse` out 1: high for one cycle on an accepted release.
- `longPulse` out 1: high for one cycle when a press has been held `LONG_CYCLES` cycles. Fires at most once per press.
- `pressCount` out 8: number of accepted presses, modulo 256.

## Operation
- **Input path.** `btnIn` is XORed with `ACTIVE_LOW` so the signal is 1 when pressed. It then passes through a 2-flop synchronizer (`s1`, `s2`). Both flops reset to 0 (not pressed).
- **Counters.**
  - `dbCnt`: width clog2(`DEBOUNCE_CYCLES`).
  - `holdCnt`: width clog2(`LONG_CYCLES`).
  - `longDone`: 1-bit flag.
  - All counters and flags are registered.
- **FSM states:** IDLE, PRESS_WAIT, HELD, RELEASE_WAIT.
- **IDLE:**
  - `s2`=1 → PRESS_WAIT, `dbCnt`←0.
- **PRESS_WAIT:**
  - `s2`=0 → IDLE. This is a bounce; no outputs change.
  - Else if `dbCnt`==`DEBOUNCE_CYCLES`-1 → HELD. Also: `pressed`←1, `pressPulse`←1, `pressCount`←`pressCount`+1 (255 wraps to 0), `holdCnt`←0, `longDone`←0.
  - Else `dbCnt`+1.
- **HELD:**
  - `s2`=0 → RELEASE_WAIT, `dbCnt`←0. `holdCnt` freezes.
  - Else if `holdCnt`==`LONG_CYCLES`-1 and `longDone`=0 → `longPulse`←1, `longDone`←1, `holdCnt` holds.
  - Else if `holdCnt`<`LONG_CYCLES`-1 → `holdCnt`+1.
- **RELEASE_WAIT:**
  - `s2`=1 → HELD. `holdCnt` resumes from its frozen value; no pulses.
  - Else if `dbCnt`==`DEBOUNCE_CYCLES`-1 → IDLE, with `pressed`←0 and `releasePulse`←1.
  - Else `dbCnt`+1.
- **Pulse outputs** default to 0 every cycle. Each strobe is registered and lasts exactly one cycle.
- **Reset:**
  - Values: `pressed`, `pressPulse`, `releasePulse` and `longPulse` are 0; `pressCount`=0; state IDLE; `dbCnt`=`holdCnt`=0; `longDone`=0; `s1`=`s2`=0.
  - `rst` takes priority over everything.
  - Reset during HELD or RELEASE_WAIT emits no `releasePulse`.
  - If the button is still held after reset, it is re-debounced and counted as a new press.

## Timing
- Edge n is the first `sysClk` edge sampling `btnIn` active, with the input stable from then on.
- Press timing:
  - `s2`=1 after edge n+1.
  - PRESS_WAIT after edge n+2.
  - `pressPulse`=1 and `pressed`=1 in the cycle after edge n+2+`DEBOUNCE_CYCLES`. `pressCount` updates on that same edge.
- Long press: `longPulse` is high in the cycle after edge n+2+`DEBOUNCE_CYCLES`+`LONG_CYCLES`, provided there was no release bounce.
- Release timing: if edge m first samples the inactive level (stable), `releasePulse`=1 and `pressed`=0 in the cycle after edge m+2+`DEBOUNCE_CYCLES`.
- Bounce rejection: any input glitch shorter than `DEBOUNCE_CYCLES` cycles (as seen at `s2`) produces no output change.
- Mutual exclusion: `pressPulse` and `releasePulse` are never high in the same cycle. `longPulse` can never coincide with `pressPulse` or `releasePulse`.

## Test plan
Use `DEBOUNCE_CYCLES`=4, `LONG_CYCLES`=20, `ACTIVE_LOW`=1 unless stated.

- **Clean press.** Drive `btnIn` 1→0 at edge 10 and hold 10 cycles, then 0→1 at edge 20 and hold → `pressPulse` high for exactly cycle after edge 16; `pressed` 1 from edge 16; `pressCount`=1; `releasePulse` high in cycle after edge 26; `pressed`=0 from edge 26.
- **Press bounce.** Drive 0 for 3 cycles, then 1 for 1 cycle, repeated 5 times, then steady 0 → exactly one `pressPulse`, asserted 4+2 edges after the final steady-0 sample; `pressCount`=1.
- **Long press.** Hold pressed 40 cycles → `longPulse` once, 20 edges after the `pressPulse` edge; no second `longPulse`. Then add a 2-cycle release glitch after 10 held cycles → `longPulse` delayed by the frozen cycles; still no `releasePulse`.
- **Count wrap.** Perform 257 clean presses → `pressCount` reads 255 after the 255th, 0 after the 256th, 1 after the 257th.
- **Reset mid-hold.** Assert `rst` for 1 cycle while in HELD with the button still pressed → all outputs 0 the next cycle; no `releasePulse`; a new `pressPulse` 4+2 edges after `rst` deasserts; `pressCount`=1.
- **Polarity.** With `ACTIVE_LOW`=0, repeat the clean press using 0→1 → identical output timing.
